// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction ROM port, redirect input and
// the instruction handshake towards the decoder.
interface instr_fetch_unit_if #(
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic                  rom_rd_en;
    logic [7:0]            rom_data;
    logic                  jump_en;
    logic [ADDR_WIDTH-1:0] jump_target;
    logic [15:0]           instr_out;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [15:0]           stall_count;

    modport master (
        output rom_addr, rom_rd_en, instr_out, instr_pc,
        output instr_valid, stall_count,
        input  rom_data, jump_en, jump_target, instr_ready
    );

    modport slave (
        input  rom_addr, rom_rd_en, instr_out, instr_pc,
        input  instr_valid, stall_count,
        output rom_data, jump_en, jump_target, instr_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Byte-wide ROM fetch, 16-bit little-endian word assembly and queueing.
// Optional stall counter enabled by FETCH_PERF_EN.
module instr_fetch_unit #(
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 2
) (
    input logic               clk,
    input logic               rst,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {ISSUE, ISSUE_HI} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  rd_hi_q, rd_hi_d;
    logic                  resp_v_q, resp_v_d;
    logic                  resp_hi_q, resp_hi_d;
    logic [ADDR_WIDTH-1:0] resp_addr_q, resp_addr_d;
    logic [7:0]            stage_q, stage_d;
    logic [ADDR_WIDTH-1:0] stage_addr_q, stage_addr_d;
    logic [15:0]           mem_q [DEPTH];
    logic [15:0]           mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] pcm_q [DEPTH];
    logic [ADDR_WIDTH-1:0] pcm_d [DEPTH];
    logic [PW-1:0]         wr_q, wr_d;
    logic [PW-1:0]         rd_q, rd_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         infl_q, infl_d;

    logic          valid;
    logic          pop;
    logic          push;
    logic          lo_ret;
    logic          credit;
    logic          lo_issue;
    logic [CW-1:0] occ_after;

    assign valid     = (cnt_q != '0);
    assign pop       = valid && bus.instr_ready;
    assign push      = resp_v_q && resp_hi_q;
    assign lo_ret    = resp_v_q && !resp_hi_q;
    assign occ_after = cnt_q - CW'(pop);
    // Words already queued plus words whose bytes are still on the way.
    assign credit    = ({1'b0, occ_after} + {1'b0, infl_q})
                       < (CW+1)'(DEPTH);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        rd_en_d      = 1'b0;
        addr_d       = addr_q;
        rd_hi_d      = 1'b0;
        resp_v_d     = rd_en_q;
        resp_hi_d    = rd_hi_q;
        resp_addr_d  = addr_q;
        stage_d      = stage_q;
        stage_addr_d = stage_addr_q;
        mem_d        = mem_q;
        pcm_d        = pcm_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        infl_d       = infl_q;
        lo_issue     = 1'b0;

        if (bus.jump_en) begin
            // Flush everything queued or in flight; restart at target.
            state_d  = ISSUE;
            pc_d     = bus.jump_target;
            resp_v_d = 1'b0;
            wr_d     = '0;
            rd_d     = '0;
            cnt_d    = '0;
            infl_d   = '0;
        end else begin
            unique case (state_q)
                ISSUE: begin
                    if (credit) begin
                        rd_en_d  = 1'b1;
                        addr_d   = pc_q;
                        pc_d     = pc_q + ADDR_WIDTH'(1);
                        state_d  = ISSUE_HI;
                        lo_issue = 1'b1;
                    end
                end
                ISSUE_HI: begin
                    rd_en_d = 1'b1;
                    rd_hi_d = 1'b1;
                    addr_d  = pc_q;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = ISSUE;
                end
                default: state_d = ISSUE;
            endcase

            if (lo_ret) begin
                stage_d      = bus.rom_data;
                stage_addr_d = resp_addr_q;
            end
            if (push) begin
                mem_d[wr_q] = {bus.rom_data, stage_q};
                pcm_d[wr_q] = stage_addr_q;
                wr_d        = wr_q + PW'(1);
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            cnt_d  = cnt_q + CW'(push) - CW'(pop);
            infl_d = infl_q + CW'(lo_issue) - CW'(push);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ISSUE;
            pc_q         <= '0;
            rd_en_q      <= 1'b0;
            addr_q       <= '0;
            rd_hi_q      <= 1'b0;
            resp_v_q     <= 1'b0;
            resp_hi_q    <= 1'b0;
            resp_addr_q  <= '0;
            stage_q      <= '0;
            stage_addr_q <= '0;
            wr_q         <= '0;
            rd_q         <= '0;
            cnt_q        <= '0;
            infl_q       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                pcm_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            rd_en_q      <= rd_en_d;
            addr_q       <= addr_d;
            rd_hi_q      <= rd_hi_d;
            resp_v_q     <= resp_v_d;
            resp_hi_q    <= resp_hi_d;
            resp_addr_q  <= resp_addr_d;
            stage_q      <= stage_d;
            stage_addr_q <= stage_addr_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            cnt_q        <= cnt_d;
            infl_q       <= infl_d;
            mem_q        <= mem_d;
            pcm_q        <= pcm_d;
        end
    end

    assign bus.rom_addr    = addr_q;
    assign bus.rom_rd_en   = rd_en_q;
    assign bus.instr_valid = valid;
    assign bus.instr_out   = mem_q[rd_q];
    assign bus.instr_pc    = pcm_q[rd_q];

`ifdef FETCH_PERF_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (bus.instr_ready && !valid && !bus.jump_en
            && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = 16'h0000;
`endif
endmodule
